// File: rtl/v5_mig34_app_pkg.sv
// Shared constants, command encodings and FSM state type for the MIG 3.4 app initiator.
package v5_mig34_app_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   localparam int unsigned APPDATA_WIDTH_DFLT = 64;
   localparam int unsigned LINE_WIDTH_DFLT    = 2 * APPDATA_WIDTH_DFLT;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR_D0  = 3'd1,
      ST_WR_D1  = 3'd2,
      ST_WR_CMD = 3'd3,
      ST_RD_CMD = 3'd4
   } state_t;

   // One line is a single BURST_LEN 4 burst, i.e. two app beats.
   function automatic int unsigned line_width(input int unsigned app_w);
      return 2 * app_w;
   endfunction

endpackage

// File: rtl/v5_mig34_app_rsp_fifo.sv
// First-word-fall-through response FIFO; head entry is always visible on o_data.
module v5_mig34_app_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 128
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_pop;
   logic             w_push;

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop & o_valid;
   assign w_push  = i_push & (~w_full | w_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/v5_mig34_app_initiator.sv
// User-side request/response initiator for the Virtex-5 MIG 3.4 DDR2 app interface.
// Optional byte-mask support is enabled by defining V5_MIG34_APP_BYTE_MASK_EN.
module v5_mig34_app_initiator
   import v5_mig34_app_pkg::*;
#(
   parameter int APPDATA_WIDTH = 64,
   parameter int ADDR_WIDTH    = 31,
   parameter int RSP_DEPTH     = 4
) (
   input  logic                          clk_sys,
   input  logic                          sys_rst,
   input  logic                          phy_init_done,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [ADDR_WIDTH-1:0]         req_addr,
   input  logic [2*APPDATA_WIDTH-1:0]    req_data,
   input  logic [2*APPDATA_WIDTH/8-1:0]  req_mask,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [2*APPDATA_WIDTH-1:0]    rsp_data,
   output logic                          err_unexp,
   output logic [2:0]                    app_cmd,
   output logic [ADDR_WIDTH-1:0]         app_addr,
   output logic                          app_af_wren,
   input  logic                          app_af_afull,
   output logic                          app_wf_wren,
   output logic [APPDATA_WIDTH-1:0]      app_data,
   output logic [APPDATA_WIDTH/8-1:0]    app_mask,
   input  logic                          app_wf_afull,
   input  logic [APPDATA_WIDTH-1:0]      app_rd_data,
   input  logic                          app_rd_data_valid
);

   localparam int LINE_W = line_width(APPDATA_WIDTH);
   localparam int MASK_W = APPDATA_WIDTH / 8;
   localparam int CW     = $clog2(RSP_DEPTH + 1);

   state_t                   r_state;
   state_t                   w_next_state;

   logic [APPDATA_WIDTH-1:0] r_req_hi;
   logic [ADDR_WIDTH-1:0]    r_req_addr;

   logic                     w_req_ready;
   logic                     w_accept;
   logic                     w_rd_accept;
   logic                     w_pop;

   logic                     w_af_wren_nxt;
   logic                     w_wf_wren_nxt;
   logic [2:0]               w_cmd_nxt;
   logic [ADDR_WIDTH-1:0]    w_addr_nxt;
   logic [APPDATA_WIDTH-1:0] w_data_nxt;
   logic [MASK_W-1:0]        w_mask_nxt;

   logic                     r_app_af_wren;
   logic                     r_app_wf_wren;
   logic [2:0]               r_app_cmd;
   logic [ADDR_WIDTH-1:0]    r_app_addr;
   logic [APPDATA_WIDTH-1:0] r_app_data;
   logic [MASK_W-1:0]        r_app_mask;

   logic [CW-1:0]            r_credit;
   logic [CW-1:0]            r_rd_pending;
   logic                     r_beat_hi;
   logic [APPDATA_WIDTH-1:0] r_rd_lo;
   logic                     r_err_unexp;
   logic                     w_beat_ok;
   logic                     w_line_done;
   logic                     w_rsp_valid;

`ifdef V5_MIG34_APP_BYTE_MASK_EN
   logic [MASK_W-1:0]        r_req_mask_hi;
`else
   logic                     w_unused_mask;
   assign w_unused_mask = ^req_mask;
`endif

   // Reset gates ready directly so that nothing is accepted while rst is held.
   assign w_req_ready = (r_state == ST_IDLE) & phy_init_done & ~app_af_afull &
                        ~app_wf_afull & (r_credit != '0) & ~sys_rst;
   assign w_accept    = req_valid & w_req_ready;
   assign w_rd_accept = w_accept & ~req_write;
   assign w_pop       = w_rsp_valid & rsp_ready;

   always_ff @(posedge clk_sys or posedge sys_rst) begin
      if (sys_rst) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next_state = req_write ? ST_WR_D0 : ST_RD_CMD;
         end
         ST_WR_D0:  w_next_state = ST_WR_D1;
         ST_WR_D1:  w_next_state = ST_WR_CMD;
         ST_WR_CMD: w_next_state = ST_IDLE;
         ST_RD_CMD: w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // App outputs are registered, so decode the state being entered; WR_D0 and
   // RD_CMD are only entered from an accept, so they take fields straight from req_*.
   always_comb begin
      w_af_wren_nxt = 1'b0;
      w_wf_wren_nxt = 1'b0;
      w_cmd_nxt     = '0;
      w_addr_nxt    = '0;
      w_data_nxt    = '0;
      w_mask_nxt    = '0;
      case (w_next_state)
         ST_WR_D0: begin
            w_wf_wren_nxt = 1'b1;
            w_data_nxt    = req_data[APPDATA_WIDTH-1:0];
`ifdef V5_MIG34_APP_BYTE_MASK_EN
            w_mask_nxt    = req_mask[MASK_W-1:0];
`endif
         end
         ST_WR_D1: begin
            w_wf_wren_nxt = 1'b1;
            w_data_nxt    = r_req_hi;
`ifdef V5_MIG34_APP_BYTE_MASK_EN
            w_mask_nxt    = r_req_mask_hi;
`endif
         end
         ST_WR_CMD: begin
            w_af_wren_nxt = 1'b1;
            w_cmd_nxt     = CMD_WRITE;
            w_addr_nxt    = r_req_addr;
         end
         ST_RD_CMD: begin
            w_af_wren_nxt = 1'b1;
            w_cmd_nxt     = CMD_READ;
            w_addr_nxt    = req_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or posedge sys_rst) begin
      if (sys_rst) begin
         r_app_af_wren <= 1'b0;
         r_app_wf_wren <= 1'b0;
         r_app_cmd     <= '0;
         r_app_addr    <= '0;
         r_app_data    <= '0;
         r_app_mask    <= '0;
      end else begin
         r_app_af_wren <= w_af_wren_nxt;
         r_app_wf_wren <= w_wf_wren_nxt;
         r_app_cmd     <= w_cmd_nxt;
         r_app_addr    <= w_addr_nxt;
         r_app_data    <= w_data_nxt;
         r_app_mask    <= w_mask_nxt;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (w_accept) begin
         r_req_hi   <= req_data[LINE_W-1:APPDATA_WIDTH];
         r_req_addr <= req_addr;
      end
   end

`ifdef V5_MIG34_APP_BYTE_MASK_EN
   always_ff @(posedge clk_sys) begin
      if (w_accept) r_req_mask_hi <= req_mask[2*MASK_W-1:MASK_W];
   end
`endif

   // Credit = FIFO free space minus reads in flight, so a returned line always fits.
   always_ff @(posedge clk_sys or posedge sys_rst) begin
      if (sys_rst) begin
         r_credit <= CW'(RSP_DEPTH);
      end else begin
         case ({w_rd_accept, w_pop})
            2'b10:   r_credit <= r_credit - CW'(1);
            2'b01:   r_credit <= r_credit + CW'(1);
            default: r_credit <= r_credit;
         endcase
      end
   end

   assign w_beat_ok   = app_rd_data_valid & (r_rd_pending != '0);
   assign w_line_done = w_beat_ok & r_beat_hi;

   always_ff @(posedge clk_sys or posedge sys_rst) begin
      if (sys_rst) begin
         r_rd_pending <= '0;
         r_beat_hi    <= 1'b0;
         r_err_unexp  <= 1'b0;
      end else begin
         case ({r_state == ST_RD_CMD, w_line_done})
            2'b10:   r_rd_pending <= r_rd_pending + CW'(1);
            2'b01:   r_rd_pending <= r_rd_pending - CW'(1);
            default: r_rd_pending <= r_rd_pending;
         endcase
         if (w_beat_ok) r_beat_hi <= ~r_beat_hi;
         if (app_rd_data_valid && r_rd_pending == '0) r_err_unexp <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (w_beat_ok && !r_beat_hi) r_rd_lo <= app_rd_data;
   end

   v5_mig34_app_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (LINE_W)
   ) u_rsp_fifo (
      .i_clk   (clk_sys),
      .i_rst   (sys_rst),
      .i_push  (w_line_done),
      .i_data  ({app_rd_data, r_rd_lo}),
      .i_pop   (rsp_ready),
      .o_valid (w_rsp_valid),
      .o_data  (rsp_data)
   );

   assign req_ready   = w_req_ready;
   assign rsp_valid   = w_rsp_valid;
   assign err_unexp   = r_err_unexp;
   assign app_af_wren = r_app_af_wren;
   assign app_wf_wren = r_app_wf_wren;
   assign app_cmd     = r_app_cmd;
   assign app_addr    = r_app_addr;
   assign app_data    = r_app_data;
   assign app_mask    = r_app_mask;

endmodule

// File: tb/tb_v5_mig34_app_initiator.sv
// Directed self-checking bench for v5_mig34_app_initiator.
module tb_v5_mig34_app_initiator;

   logic         clk_sys = 1'b0;
   logic         sys_rst;
   logic         phy_init_done;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [30:0]  req_addr;
   logic [127:0] req_data;
   logic [15:0]  req_mask;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [127:0] rsp_data;
   logic         err_unexp;
   logic [2:0]   app_cmd;
   logic [30:0]  app_addr;
   logic         app_af_wren;
   logic         app_af_afull;
   logic         app_wf_wren;
   logic [63:0]  app_data;
   logic [7:0]   app_mask;
   logic         app_wf_afull;
   logic [63:0]  app_rd_data;
   logic         app_rd_data_valid;

   int checks = 0;
   int errors = 0;

`ifdef V5_MIG34_APP_BYTE_MASK_EN
   localparam logic [7:0] EXP_M0 = 8'hF0;
`else
   localparam logic [7:0] EXP_M0 = 8'h00;
`endif

   always #5 clk_sys = ~clk_sys;

   v5_mig34_app_initiator dut (
      .clk_sys           (clk_sys),
      .sys_rst           (sys_rst),
      .phy_init_done     (phy_init_done),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_data          (req_data),
      .req_mask          (req_mask),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_data          (rsp_data),
      .err_unexp         (err_unexp),
      .app_cmd           (app_cmd),
      .app_addr          (app_addr),
      .app_af_wren       (app_af_wren),
      .app_af_afull      (app_af_afull),
      .app_wf_wren       (app_wf_wren),
      .app_data          (app_data),
      .app_mask          (app_mask),
      .app_wf_afull      (app_wf_afull),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid)
   );

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle_inputs;
      req_valid         = 1'b0;
      req_write         = 1'b0;
      req_addr          = '0;
      req_data          = '0;
      req_mask          = '0;
      rsp_ready         = 1'b0;
      app_af_afull      = 1'b0;
      app_wf_afull      = 1'b0;
      app_rd_data       = '0;
      app_rd_data_valid = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      phy_init_done = 1'b1;
      sys_rst = 1'b1;
      tick();
      tick();
      sys_rst = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      logic [241:0] outs;
      idle_inputs();
      phy_init_done = 1'b1;
      req_valid = 1'b1;
      sys_rst = 1'b1;
      tick();
      tick();
      outs = {req_ready, app_af_wren, app_wf_wren, app_cmd, app_addr, app_data,
              app_mask, rsp_valid, rsp_data, err_unexp};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0", req_ready);
      end
      req_valid = 1'b0;
      sys_rst = 1'b0;
      tick();
   endtask

   task automatic test_init_gate;
      do_reset();
      phy_init_done = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 31'h55;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (req_ready !== 1'b0 || app_af_wren !== 1'b0 || app_wf_wren !== 1'b0) begin
            errors++;
            $display("FAIL init_gate_%0d: ready/af/wf %b%b%b expected 000", i,
                     req_ready, app_af_wren, app_wf_wren);
         end
         tick();
      end
      phy_init_done = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL init_ready: got %b expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (app_af_wren !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 31'h55) begin
         errors++;
         $display("FAIL init_rd_cmd: wren %b cmd %b addr %h expected 1 001 55",
                  app_af_wren, app_cmd, app_addr);
      end
   endtask

   task automatic test_write;
      do_reset();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 31'h100;
      req_data  = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
      req_mask  = 16'h00F0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_accept: ready %b expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      req_data  = '0;
      req_mask  = '0;
      checks++;
      if (app_wf_wren !== 1'b1 || app_data !== 64'h2222_2222_2222_2222 ||
          app_mask !== EXP_M0 || app_af_wren !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL wr_beat0: wf %b data %h mask %h af %b rdy %b expected 1 2222.. %h 0 0",
                  app_wf_wren, app_data, app_mask, app_af_wren, req_ready, EXP_M0);
      end
      tick();
      checks++;
      if (app_wf_wren !== 1'b1 || app_data !== 64'h1111_1111_1111_1111 ||
          app_mask !== 8'h00 || app_af_wren !== 1'b0) begin
         errors++;
         $display("FAIL wr_beat1: wf %b data %h mask %h af %b expected 1 1111.. 00 0",
                  app_wf_wren, app_data, app_mask, app_af_wren);
      end
      tick();
      checks++;
      if (app_af_wren !== 1'b1 || app_cmd !== 3'b000 || app_addr !== 31'h100 ||
          app_wf_wren !== 1'b0) begin
         errors++;
         $display("FAIL wr_cmd: af %b cmd %b addr %h wf %b expected 1 000 100 0",
                  app_af_wren, app_cmd, app_addr, app_wf_wren);
      end
      tick();
      checks++;
      if (req_ready !== 1'b1 || app_af_wren !== 1'b0) begin
         errors++;
         $display("FAIL wr_ready_again: ready %b af %b expected 1 0", req_ready, app_af_wren);
      end
   endtask

   task automatic test_read_resp;
      do_reset();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 31'h200;
      tick();
      req_valid = 1'b0;
      checks++;
      if (app_af_wren !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 31'h200) begin
         errors++;
         $display("FAIL rd_cmd: af %b cmd %b addr %h expected 1 001 200",
                  app_af_wren, app_cmd, app_addr);
      end
      tick();
      req_valid = 1'b1;
      req_addr  = 31'h201;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rd_back_to_back: ready %b expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      tick();
      app_rd_data_valid = 1'b1;
      app_rd_data = 64'hAAAA_0000_0000_0001;
      tick();
      app_rd_data = 64'hBBBB_0000_0000_0001;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rsp_half_line: valid %b expected 0", rsp_valid);
      end
      tick();
      app_rd_data_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== {64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0001}) begin
         errors++;
         $display("FAIL rsp_line1: valid %b data %h expected 1 BBBB..1AAAA..1", rsp_valid, rsp_data);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== {64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0001}) begin
         errors++;
         $display("FAIL rsp_hold: valid %b data %h expected line1 held", rsp_valid, rsp_data);
      end
      app_rd_data_valid = 1'b1;
      app_rd_data = 64'hAAAA_0000_0000_0002;
      tick();
      app_rd_data = 64'hBBBB_0000_0000_0002;
      rsp_ready = 1'b1;
      tick();
      app_rd_data_valid = 1'b0;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0002}) begin
         errors++;
         $display("FAIL rsp_push_pop: valid %b data %h expected 1 line2", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rsp_drain: valid %b expected 0 (occupancy should have been 1)", rsp_valid);
      end
   endtask

   task automatic test_credit;
      do_reset();
      req_write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_addr  = 31'h300 + 31'(i);
         #1;
         checks++;
         if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_rd_%0d: ready %b expected 1", i, req_ready);
         end
         tick();
         req_valid = 1'b0;
         tick();
      end
      req_valid = 1'b1;
      req_addr  = 31'h304;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL credit_exhausted: ready %b expected 0", req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         app_rd_data_valid = 1'b1;
         app_rd_data = 64'hC0 + 64'(i);
         tick();
         app_rd_data = 64'hD0 + 64'(i);
         tick();
      end
      app_rd_data_valid = 1'b0;
      tick();
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== {64'hD0, 64'hC0}) begin
         errors++;
         $display("FAIL credit_full: ready %b valid %b data %h expected 0 1 D0/C0",
                  req_ready, rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_data !== {64'hD1, 64'hC1}) begin
         errors++;
         $display("FAIL credit_return: ready %b data %h expected 1 D1/C1", req_ready, rsp_data);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (app_af_wren !== 1'b1 || app_addr !== 31'h304) begin
         errors++;
         $display("FAIL credit_fifth: af %b addr %h expected 1 304", app_af_wren, app_addr);
      end
   endtask

   task automatic test_afull;
      do_reset();
      app_af_afull = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 31'h400;
      req_data  = {64'h4444, 64'h3333};
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL afull_block: ready %b expected 0", req_ready);
      end
      tick();
      checks++;
      if (app_af_wren !== 1'b0 || app_wf_wren !== 1'b0) begin
         errors++;
         $display("FAIL afull_no_wren: af %b wf %b expected 0 0", app_af_wren, app_wf_wren);
      end
      app_af_afull = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL afull_release: ready %b expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      tick();
      app_af_afull = 1'b1;
      app_wf_afull = 1'b1;
      checks++;
      if (app_wf_wren !== 1'b1 || app_data !== 64'h4444) begin
         errors++;
         $display("FAIL afull_wr_d1: wf %b data %h expected 1 4444", app_wf_wren, app_data);
      end
      tick();
      checks++;
      if (app_af_wren !== 1'b1 || app_cmd !== 3'b000 || app_addr !== 31'h400) begin
         errors++;
         $display("FAIL afull_wr_cmd: af %b cmd %b addr %h expected 1 000 400",
                  app_af_wren, app_cmd, app_addr);
      end
      tick();
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL afull_after: ready %b expected 0", req_ready);
      end
      app_af_afull = 1'b0;
      app_wf_afull = 1'b0;
   endtask

   task automatic test_unexp;
      do_reset();
      checks++;
      if (err_unexp !== 1'b0) begin
         errors++;
         $display("FAIL unexp_clear: got %b expected 0", err_unexp);
      end
      app_rd_data_valid = 1'b1;
      app_rd_data = 64'hDEAD;
      tick();
      app_rd_data_valid = 1'b0;
      checks++;
      if (err_unexp !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL unexp_set: err %b valid %b expected 1 0", err_unexp, rsp_valid);
      end
      tick();
      tick();
      checks++;
      if (err_unexp !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL unexp_sticky: err %b valid %b expected 1 0", err_unexp, rsp_valid);
      end
   endtask

   task automatic test_reset_mid;
      logic [241:0] outs;
      do_reset();
      app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 31'h500;
      req_data  = {64'h6666, 64'h5555};
      req_mask  = 16'hFFFF;
      tick();
      req_valid = 1'b0;
      checks++;
      if (app_wf_wren !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: wf %b expected 1", app_wf_wren);
      end
      #2;
      sys_rst = 1'b1;
      #1;
      outs = {req_ready, app_af_wren, app_wf_wren, app_cmd, app_addr, app_data,
              app_mask, rsp_valid, rsp_data, err_unexp};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL rstmid_async: got %h expected 0", outs);
      end
      tick();
      sys_rst = 1'b0;
      tick();
      req_write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_addr  = 31'h600 + 31'(i);
         #1;
         checks++;
         if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_credit_%0d: ready %b expected 1", i, req_ready);
         end
         tick();
         req_valid = 1'b0;
         tick();
      end
      req_valid = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_credit_limit: ready %b expected 0", req_ready);
      end
      req_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      phy_init_done = 1'b1;
      sys_rst = 1'b1;
      test_reset();
      test_init_gate();
      test_write();
      test_read_resp();
      test_credit();
      test_afull();
      test_unexp();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
